// File: rtl/color_marker_tracker.sv
// Multi-marker colour tracker: classifies RGB pixels against programmable colour windows,
// accumulates per-marker bounding boxes and counts, and publishes box centres at frame end.
module color_marker_tracker #(
    parameter int NUM_MARKERS = 3,
    parameter int COLOR_W     = 12,
    parameter int COORD_W     = 11,
    parameter int CNT_W       = 20,
    parameter int MIN_PIXELS  = 16
) (
    input  logic                           iCLK,
    input  logic                           iRST,
    input  logic                           iDVAL,
    input  logic                           iFRAME_START,
    input  logic                           iFRAME_END,
    input  logic [COORD_W-1:0]             iX_Cont,
    input  logic [COORD_W-1:0]             iY_Cont,
    input  logic [COLOR_W-1:0]             in_R,
    input  logic [COLOR_W-1:0]             in_G,
    input  logic [COLOR_W-1:0]             in_B,
    input  logic                           cfg_we,
    input  logic [2:0]                     cfg_marker,
    input  logic [2:0]                     cfg_field,
    input  logic [COLOR_W-1:0]             cfg_data,
    output logic [NUM_MARKERS*COORD_W-1:0] oCenter_X,
    output logic [NUM_MARKERS*COORD_W-1:0] oCenter_Y,
    output logic [NUM_MARKERS*CNT_W-1:0]   oCount,
    output logic [NUM_MARKERS-1:0]         oFound,
    output logic                           oValid
);

    typedef enum logic [1:0] {IDLE, ACTIVE, PUBLISH} state_t;

    state_t state, state_nxt;
    logic   publish;

    logic [COLOR_W-1:0]     act_lo [NUM_MARKERS][3];
    logic [COLOR_W-1:0]     act_hi [NUM_MARKERS][3];
    logic [NUM_MARKERS-1:0] act_en;
    logic [COLOR_W-1:0]     act_lo_nxt [NUM_MARKERS][3];
    logic [COLOR_W-1:0]     act_hi_nxt [NUM_MARKERS][3];
    logic [NUM_MARKERS-1:0] act_en_nxt;
    logic [COLOR_W-1:0]     sh_lo [NUM_MARKERS][3];
    logic [COLOR_W-1:0]     sh_hi [NUM_MARKERS][3];
    logic [NUM_MARKERS-1:0] sh_en;

    logic [COLOR_W-1:0]     pix [3];
    logic [NUM_MARKERS-1:0] match;

    logic                   s1_dval, s1_start, s1_end;
    logic [COORD_W-1:0]     s1_x, s1_y;
    logic [NUM_MARKERS-1:0] s1_match;

    logic [COORD_W-1:0] min_x [NUM_MARKERS];
    logic [COORD_W-1:0] max_x [NUM_MARKERS];
    logic [COORD_W-1:0] min_y [NUM_MARKERS];
    logic [COORD_W-1:0] max_y [NUM_MARKERS];
    logic [CNT_W-1:0]   cnt   [NUM_MARKERS];
    logic [COORD_W-1:0] min_x_nxt [NUM_MARKERS];
    logic [COORD_W-1:0] max_x_nxt [NUM_MARKERS];
    logic [COORD_W-1:0] min_y_nxt [NUM_MARKERS];
    logic [COORD_W-1:0] max_y_nxt [NUM_MARKERS];
    logic [CNT_W-1:0]   cnt_nxt   [NUM_MARKERS];

    logic [COORD_W-1:0]     cx_pub [NUM_MARKERS];
    logic [COORD_W-1:0]     cy_pub [NUM_MARKERS];
    logic [NUM_MARKERS-1:0] found_pub;
    logic                   acc_en;

    always_comb begin
        act_lo_nxt = act_lo;
        act_hi_nxt = act_hi;
        act_en_nxt = act_en;
        for (int m = 0; m < NUM_MARKERS; m++) begin
            if (cfg_we && cfg_marker == 3'(m)) begin
                for (int c = 0; c < 3; c++) begin
                    if (cfg_field == 3'(2*c))   act_lo_nxt[m][c] = cfg_data;
                    if (cfg_field == 3'(2*c+1)) act_hi_nxt[m][c] = cfg_data;
                end
                if (cfg_field == 3'd6) act_en_nxt[m] = cfg_data[0];
            end
        end
    end

    // Shadow bank captures the active bank (including a same-cycle write) at frame start.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            for (int m = 0; m < NUM_MARKERS; m++) begin
                for (int c = 0; c < 3; c++) begin
                    act_lo[m][c] <= '0;
                    act_hi[m][c] <= '0;
                    sh_lo[m][c]  <= '0;
                    sh_hi[m][c]  <= '0;
                end
            end
            act_en <= '0;
            sh_en  <= '0;
        end else begin
            act_lo <= act_lo_nxt;
            act_hi <= act_hi_nxt;
            act_en <= act_en_nxt;
            if (iFRAME_START) begin
                sh_lo <= act_lo_nxt;
                sh_hi <= act_hi_nxt;
                sh_en <= act_en_nxt;
            end
        end
    end

    // The frame-start pixel belongs to the new frame, so it sees the bank being copied in.
    always_comb begin
        pix[0] = in_R;
        pix[1] = in_G;
        pix[2] = in_B;
        match  = '0;
        for (int m = 0; m < NUM_MARKERS; m++) begin
            logic hit;
            hit = iFRAME_START ? act_en_nxt[m] : sh_en[m];
            for (int c = 0; c < 3; c++) begin
                logic [COLOR_W-1:0] lo, hi;
                lo  = iFRAME_START ? act_lo_nxt[m][c] : sh_lo[m][c];
                hi  = iFRAME_START ? act_hi_nxt[m][c] : sh_hi[m][c];
                hit = hit && (pix[c] >= lo) && (pix[c] <= hi);
            end
            match[m] = hit;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            s1_dval  <= 1'b0;
            s1_start <= 1'b0;
            s1_end   <= 1'b0;
            s1_x     <= '0;
            s1_y     <= '0;
            s1_match <= '0;
        end else begin
            s1_dval  <= iDVAL;
            s1_start <= iFRAME_START;
            s1_end   <= iFRAME_END;
            s1_x     <= iX_Cont;
            s1_y     <= iY_Cont;
            s1_match <= match;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        publish   = 1'b0;
        if (s1_end) begin
            state_nxt = PUBLISH;
            publish   = 1'b1;
        end else if (s1_start) begin
            state_nxt = ACTIVE;
        end else if (state == PUBLISH) begin
            state_nxt = IDLE;
        end
    end

    // Clear-then-update lets a frame-start pixel seed the new frame in the same cycle.
    always_comb begin
        acc_en    = s1_start || (state == ACTIVE);
        min_x_nxt = min_x;
        max_x_nxt = max_x;
        min_y_nxt = min_y;
        max_y_nxt = max_y;
        cnt_nxt   = cnt;
        for (int m = 0; m < NUM_MARKERS; m++) begin
            if (s1_start) begin
                min_x_nxt[m] = '1;
                max_x_nxt[m] = '0;
                min_y_nxt[m] = '1;
                max_y_nxt[m] = '0;
                cnt_nxt[m]   = '0;
            end
            if (acc_en && s1_dval && s1_match[m]) begin
                if (s1_x < min_x_nxt[m]) min_x_nxt[m] = s1_x;
                if (s1_x > max_x_nxt[m]) max_x_nxt[m] = s1_x;
                if (s1_y < min_y_nxt[m]) min_y_nxt[m] = s1_y;
                if (s1_y > max_y_nxt[m]) max_y_nxt[m] = s1_y;
                if (cnt_nxt[m] != {CNT_W{1'b1}}) cnt_nxt[m] = cnt_nxt[m] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            for (int m = 0; m < NUM_MARKERS; m++) begin
                min_x[m] <= '1;
                max_x[m] <= '0;
                min_y[m] <= '1;
                max_y[m] <= '0;
                cnt[m]   <= '0;
            end
        end else begin
            min_x <= min_x_nxt;
            max_x <= max_x_nxt;
            min_y <= min_y_nxt;
            max_y <= max_y_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Sum in one extra bit so centres near the coordinate limit do not wrap.
    always_comb begin
        found_pub = '0;
        for (int m = 0; m < NUM_MARKERS; m++) begin
            logic [COORD_W:0] sum_x, sum_y;
            sum_x        = {1'b0, min_x_nxt[m]} + {1'b0, max_x_nxt[m]};
            sum_y        = {1'b0, min_y_nxt[m]} + {1'b0, max_y_nxt[m]};
            found_pub[m] = (cnt_nxt[m] >= CNT_W'(MIN_PIXELS));
            cx_pub[m]    = found_pub[m] ? COORD_W'(sum_x >> 1) : '0;
            cy_pub[m]    = found_pub[m] ? COORD_W'(sum_y >> 1) : '0;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oCenter_X <= '0;
            oCenter_Y <= '0;
            oCount    <= '0;
            oFound    <= '0;
            oValid    <= 1'b0;
        end else begin
            oValid <= publish;
            if (publish) begin
                for (int m = 0; m < NUM_MARKERS; m++) begin
                    oCenter_X[m*COORD_W +: COORD_W] <= cx_pub[m];
                    oCenter_Y[m*COORD_W +: COORD_W] <= cy_pub[m];
                    oCount[m*CNT_W +: CNT_W]        <= cnt_nxt[m];
                end
                oFound <= found_pub;
            end
        end
    end

endmodule
